// File: rtl/h264_stream_feeder.sv
// Host byte stream to 16-bit decoder word feeder: packs byte pairs MSB-first,
// buffers them in a FIFO and delivers one word per decoder request. Optional STREAM_STATS_EN adds counters.
module h264_stream_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            host_data,
    input  logic                  host_valid,
    input  logic                  host_last,
    output logic                  host_ready,
    input  logic                  bi_next,
    output logic [15:0]           bo_data,
    output logic                  bo_we,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  eos_done
`ifdef STREAM_STATS_EN
    ,
    output logic [15:0]           sc_count,
    output logic [31:0]           byte_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] S_IDLE_HI = 2'd0;
    localparam logic [1:0] S_HAVE_HI = 2'd1;
    localparam logic [1:0] S_PAD     = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    logic [1:0]            state_q, state_d;
    logic [7:0]            hi_q, hi_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [15:0]           bo_data_q, bo_data_d;
    logic                  bo_we_q, bo_we_d;
    logic                  eos_q, eos_d;
    logic                  init_q, init_d;
    logic [15:0]           mem [DEPTH];

    logic        full, empty, accept, push, pop;
    logic [15:0] push_data;

    // Level never exceeds DEPTH, so its MSB alone marks the full condition.
    assign full  = level_q[DEPTH_LOG2];
    assign empty = (level_q == '0);
    assign pop   = bi_next && !empty;

    always_comb begin
        host_ready = init_q && !full && (state_q == S_IDLE_HI || state_q == S_HAVE_HI);
        accept     = host_valid && host_ready;
        init_d     = 1'b1;
        state_d    = state_q;
        hi_d       = hi_q;
        push       = 1'b0;
        push_data  = 16'h0000;
        eos_d      = 1'b0;
        case (state_q)
            S_IDLE_HI: if (accept) begin
                hi_d    = host_data;
                state_d = host_last ? S_PAD : S_HAVE_HI;
            end
            S_HAVE_HI: if (accept) begin
                push      = 1'b1;
                push_data = {hi_q, host_data};
                state_d   = host_last ? S_DRAIN : S_IDLE_HI;
            end
            S_PAD: if (!full) begin
                push      = 1'b1;
                push_data = {hi_q, 8'h00};
                state_d   = S_DRAIN;
            end
            default: if (empty) begin
                // Empty means the final pop already landed in bo_data_q this cycle.
                eos_d   = 1'b1;
                state_d = S_IDLE_HI;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        bo_we_d   = pop;
        bo_data_d = pop ? mem[rd_ptr_q] : bo_data_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE_HI;
            hi_q      <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            bo_data_q <= 16'h0000;
            bo_we_q   <= 1'b0;
            eos_q     <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            bo_data_q <= bo_data_d;
            bo_we_q   <= bo_we_d;
            eos_q     <= eos_d;
            init_q    <= init_d;
        end
    end

    // NOTE: storage is not reset; pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign bo_data    = bo_data_q;
    assign bo_we      = bo_we_q;
    assign fifo_level = level_q;
    assign eos_done   = eos_q;

`ifdef STREAM_STATS_EN
    logic [15:0] sc_q, sc_d;
    logic [31:0] bytes_q, bytes_d;
    logic [7:0]  b1_q, b1_d, b2_q, b2_d;
    logic [1:0]  hist_q, hist_d;

    always_comb begin
        sc_d    = sc_q;
        bytes_d = bytes_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        hist_d  = hist_q;
        if (accept) begin
            bytes_d = bytes_q + 32'd1;
            if (hist_q == 2'd2 && b2_q == 8'h00 && b1_q == 8'h00 &&
                host_data == 8'h01 && sc_q != 16'hFFFF)
                sc_d = sc_q + 16'd1;
            // History restarts at stream end so start codes never straddle streams.
            if (host_last) begin
                hist_d = 2'd0;
            end else begin
                b2_d   = b1_q;
                b1_d   = host_data;
                hist_d = (hist_q == 2'd2) ? 2'd2 : hist_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sc_q    <= 16'h0000;
            bytes_q <= 32'h0;
            b1_q    <= 8'h00;
            b2_q    <= 8'h00;
            hist_q  <= 2'd0;
        end else begin
            sc_q    <= sc_d;
            bytes_q <= bytes_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            hist_q  <= hist_d;
        end
    end

    assign sc_count   = sc_q;
    assign byte_count = bytes_q;
`endif

endmodule

// File: tb/tb_h264_stream_feeder.sv
// Scoreboard bench for h264_stream_feeder: expected words queued at stimulus time,
// a negedge monitor pops and compares every delivered word.
module tb_h264_stream_feeder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  host_data = 8'h00;
    logic        host_valid = 1'b0;
    logic        host_last = 1'b0;
    logic        host_ready;
    logic        bi_next = 1'b0;
    logic [15:0] bo_data;
    logic        bo_we;
    logic [4:0]  fifo_level;
    logic        eos_done;
`ifdef STREAM_STATS_EN
    logic [15:0] sc_count;
    logic [31:0] byte_count;
`endif

    h264_stream_feeder #(.DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_last  (host_last),
        .host_ready (host_ready),
        .bi_next    (bi_next),
        .bo_data    (bo_data),
        .bo_we      (bo_we),
        .fifo_level (fifo_level),
        .eos_done   (eos_done)
`ifdef STREAM_STATS_EN
        ,
        .sc_count   (sc_count),
        .byte_count (byte_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          rx_count = 0;
    int          eos_count = 0;
    int          bytes_sent = 0;
    logic        eos_prev = 1'b0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: every delivered word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bo_we) begin
                rx_count++;
                if (exp_q.size() == 0) check("unexpected_word", {16'h0, bo_data}, 32'hDEAD);
                else check("word_order", {16'h0, bo_data}, {16'h0, exp_q.pop_front()});
            end
            if (eos_done) begin
                eos_count++;
                if (eos_prev) check("eos_single_cycle", 32'd1, 32'd0);
            end
            eos_prev = eos_done;
        end else begin
            eos_prev = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        host_data  = b;
        host_valid = 1'b1;
        host_last  = last;
        @(negedge clk);
        while (!host_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!host_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bytes_sent++;
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while (!(fifo_level == 0 && exp_q.size() == 0 && !bo_we) && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("drain_done", {27'h0, fifo_level} | 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        host_valid = 1'b0;
        host_last = 1'b0;
        bi_next = 1'b0;
        exp_q.delete();
        #1;
        check("rst_host_ready", {31'h0, host_ready}, 32'd0);
        check("rst_bo_we", {31'h0, bo_we}, 32'd0);
        check("rst_bo_data", {16'h0, bo_data}, 32'h0);
        check("rst_fifo_level", {27'h0, fifo_level}, 32'd0);
        check("rst_eos_done", {31'h0, eos_done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int eos_before;
        int n;

        // Reset state and first-clock host_ready rise.
        #1;
        check("init_host_ready", {31'h0, host_ready}, 32'd0);
        check("init_bo_we", {31'h0, bo_we}, 32'd0);
        check("init_bo_data", {16'h0, bo_data}, 32'h0);
        check("init_fifo_level", {27'h0, fifo_level}, 32'd0);
        check("init_eos_done", {31'h0, eos_done}, 32'd0);
        #21;
        reset_n = 1'b1;
        #1;
        check("ready_before_clock", {31'h0, host_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_clock", {31'h0, host_ready}, 32'd1);

        // Test 1: 12 34 56 78 with bi_next high, latency 1 after pop.
        bi_next = 1'b1;
        send_byte(8'h12, 1'b0);
        exp_q.push_back(16'h1234);
        send_byte(8'h34, 1'b0);
        @(negedge clk);
        check("t1_level_after_push", {27'h0, fifo_level}, 32'd1);
        check("t1_we_before_pop", {31'h0, bo_we}, 32'd0);
        @(negedge clk);
        check("t1_we_after_pop", {31'h0, bo_we}, 32'd1);
        check("t1_data_after_pop", {16'h0, bo_data}, 32'h1234);
        @(posedge clk);
        #1;
        send_byte(8'h56, 1'b0);
        exp_q.push_back(16'h5678);
        send_byte(8'h78, 1'b0);
        wait_drain();

        // Test 2: fill to 16 with bi_next low, 8 bytes left pending.
        bi_next = 1'b0;
        bytes_sent = 0;
        rx_count = 0;
        fork
            begin
                for (int i = 0; i < 40; i += 2) begin
                    send_byte(8'(i + 1), 1'b0);
                    exp_q.push_back({8'(i + 1), 8'(i + 2)});
                    send_byte(8'(i + 2), 1'b0);
                end
            end
            begin
                n = 0;
                @(negedge clk);
                while (fifo_level != 5'd16 && n < 200) begin
                    n++;
                    @(negedge clk);
                end
                check("t2_level_full", {27'h0, fifo_level}, 32'd16);
                check("t2_ready_full", {31'h0, host_ready}, 32'd0);
                repeat (3) @(negedge clk);
                check("t2_bytes_accepted", 32'(bytes_sent), 32'd32);
                @(posedge clk);
                #1;
                bi_next = 1'b1;
            end
        join
        wait_drain();
        check("t2_words_out", 32'(rx_count), 32'd20);

        // Test 3: odd stream AB CD EF(last) -> ABCD, EF00, one eos pulse.
        eos_before = eos_count;
        send_byte(8'hAB, 1'b0);
        exp_q.push_back(16'hABCD);
        send_byte(8'hCD, 1'b0);
        exp_q.push_back(16'hEF00);
        send_byte(8'hEF, 1'b1);
        n = 0;
        @(negedge clk);
        check("t3_ready_in_pad", {31'h0, host_ready}, 32'd0);
        while (!eos_done && n < 50) begin
            if (host_ready) check("t3_ready_before_eos", 32'd1, 32'd0);
            n++;
            @(negedge clk);
        end
        check("t3_eos_seen", {31'h0, eos_done}, 32'd1);
        check("t3_words_before_eos", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("t3_eos_dropped", {31'h0, eos_done}, 32'd0);
        check("t3_ready_after_eos", {31'h0, host_ready}, 32'd1);
        check("t3_eos_count", 32'(eos_count - eos_before), 32'd1);
        @(posedge clk);
        #1;

        // Test 4: level 5, then push and pop concurrently for 10 cycles.
        bi_next = 1'b0;
        for (int i = 0; i < 10; i += 2) begin
            send_byte(8'(8'h20 + i), 1'b0);
            exp_q.push_back({8'(8'h20 + i), 8'(8'h21 + i)});
            send_byte(8'(8'h21 + i), 1'b0);
        end
        @(negedge clk);
        check("t4_level_start", {27'h0, fifo_level}, 32'd5);
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 20; i += 2) begin
                    send_byte(8'(8'h40 + i), 1'b0);
                    exp_q.push_back({8'(8'h40 + i), 8'(8'h41 + i)});
                    send_byte(8'(8'h41 + i), 1'b0);
                end
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    bi_next = ~bi_next;
                    @(posedge clk);
                    #1;
                end
                bi_next = 1'b1;
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    if (fifo_level < 5'd4 || fifo_level > 5'd6)
                        check("t4_level_range", {27'h0, fifo_level}, 32'd5);
                end
                check("t4_level_in_range", {31'h0, (fifo_level >= 5'd4 && fifo_level <= 5'd6)}, 32'd1);
            end
        join
        wait_drain();

        // Test 5: reset mid-stream at level 7 with 9A held.
        bi_next = 1'b0;
        for (int i = 0; i < 14; i += 2) begin
            send_byte(8'(8'h60 + i), 1'b0);
            exp_q.push_back({8'(8'h60 + i), 8'(8'h61 + i)});
            send_byte(8'(8'h61 + i), 1'b0);
        end
        send_byte(8'h9A, 1'b0);
        @(negedge clk);
        check("t5_level_before_reset", {27'h0, fifo_level}, 32'd7);
        do_reset();
        rx_count = 0;
        bi_next = 1'b1;
        send_byte(8'h11, 1'b0);
        exp_q.push_back(16'h1122);
        send_byte(8'h22, 1'b0);
        wait_drain();
        check("t5_words_out", 32'(rx_count), 32'd1);

`ifdef STREAM_STATS_EN
        // Test 6: start-code and byte counters.
        do_reset();
        bi_next = 1'b1;
        eos_before = eos_count;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0165);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h65, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);
        check("t6_sc_count", {16'h0, sc_count}, 32'd2);
        check("t6_byte_count", byte_count, 32'd8);
        check("t6_eos_count", 32'(eos_count - eos_before), 32'd1);
`endif

        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
